proc_mem_arbiter: RTL and testbench
===================================

Name: proc_mem_arbiter

Overview:
- Shares one memory request/response port between two requesters: port 0 (instruction fetch) and port 1 (data access).
- Sits between the processor's imem/dmem bypass queues and a single-ported memory or cache.
- Round-robin arbitration on requests. An in-order owner FIFO steers each response back to the requester that issued it.
- Memory returns responses in request order.

Parameters:
- p_max_outstanding, 4, max requests in flight (owner FIFO depth); power of 2, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_msg  in  77  mem_req_4B_t from requester 0
- req0_val  in  1  requester 0 request valid
- req0_rdy  out  1  requester 0 request accepted
- req1_msg  in  77  mem_req_4B_t from requester 1
- req1_val  in  1  requester 1 request valid
- req1_rdy  out  1  requester 1 request accepted
- resp0_msg  out  47  mem_resp_4B_t to requester 0
- resp0_val  out  1  response 0 valid
- resp0_rdy  in  1  requester 0 accepts response
- resp1_msg  out  47  mem_resp_4B_t to requester 1
- resp1_val  out  1  response 1 valid
- resp1_rdy  in  1  requester 1 accepts response
- memreq_msg  out  77  request to memory
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory accepts request
- memresp_msg  in  47  response from memory
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  arbiter accepts response

Behaviour:
- Reset: all val/rdy outputs 0; owner FIFO empty; priority pointer = 0; FSM = ARB.
- FSM state ARB:
  - Eligible set = {i : reqi_val} when FIFO not full; empty when FIFO full.
  - Winner: if both eligible, the one at the priority pointer; otherwise the single eligible requester.
  - memreq_msg/memreq_val = winner's msg/val, combinationally (zero-latency path).
  - reqi_rdy = (i == winner) && memreq_rdy. The loser's rdy = 0.
  - Winner fires (memreq_rdy = 1): push winner id into owner FIFO; pointer <= ~winner; stay in ARB.
  - Winner presented but memreq_rdy = 0: latch winner into lock_id; go to HOLD.
- FSM state HOLD:
  - Present only lock_id's request; the other requester's rdy = 0 even if it is valid.
  - Requesters obey val/rdy, so val stays high and msg stays stable.
  - On fire: push lock_id; pointer <= ~lock_id; go to ARB.
  - FIFO cannot fill during HOLD, because pushes happen only on fire.
- Full FIFO: memreq_val = 0 and both reqi_rdy = 0 until a response dequeues. No push and pop of a full FIFO in the same cycle; the freed slot is usable next cycle.
- Responses:
  - head = FIFO front.
  - resp_head_val = memresp_val && !empty. resp_other_val = 0.
  - Both respi_msg = memresp_msg (broadcast; gated by val).
  - memresp_rdy = !empty && resp_head_rdy.
  - On fire, pop the FIFO.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
- memresp_val while FIFO empty: memresp_rdy = 0 and the response is not consumed. This is a protocol error, flagged by a simulation-only assertion.
- Request message passes through unmodified (opaque not rewritten).
- Reset mid-operation: FIFO, FSM and pointer are cleared. In-flight memory responses are the environment's responsibility to flush.

Optional Feature:
- Macro: PROC_MEM_ARB_STATS_EN.
- When defined, add outputs:
  - num_grants0 (32 bits): saturating count of req0 fires.
  - num_grants1 (32 bits): saturating count of req1 fires.
  - num_conflicts (32 bits): saturating count of cycles in ARB with both valid and FIFO not full.
  - All reset to 0.
- When undefined: these ports and counters do not exist. Arbitration is identical either way.

Decomposition:
- Shared package holds:
  - requester-id typedef (1 bit)
  - arbiter FSM state enum (ARB, HOLD)
  - constants REQ_ID_IMEM = 0 and REQ_ID_DMEM = 1
- Message types come from the existing mem-msgs definitions.
- One sub-module: proc_mem_arb_owner_fifo. It is a synchronous owner-ID FIFO with depth p_max_outstanding, full/empty flags, and simultaneous push/pop.

Test Plan:
- Both valid every cycle, memreq_rdy = 1, ordered memory with 1-cycle latency:
  - grants alternate 0,1,0,1 starting with 0;
  - responses addr 0x100 → resp0 and 0x2000 → resp1, matching issue order.
- req1 alone valid with addr 0x2004, memreq_rdy held low for 3 cycles; req0 rises in cycle 2:
  - memreq_msg stays 0x2004 with req1 granted (HOLD);
  - req0 is granted the cycle after the fire.
- Memory never responds, both requesters always valid:
  - exactly 4 fires, then memreq_val = 0;
  - one response popped → one further fire the next cycle.
- Responses with resp1_rdy low for 2 cycles while head owner = 1:
  - memresp_rdy = 0 and resp0_val = 0;
  - the second response (owner 0) waits until the head pops.
- Reset asserted with 3 requests outstanding:
  - FIFO empty, pointer = 0, all rdy = 0 during reset;
  - fresh traffic arbitrates from port 0.
- With PROC_MEM_ARB_STATS_EN, 10 cycles of both valid, memreq_rdy = 1, FIFO drained each cycle:
  - num_grants0 = 5, num_grants1 = 5, num_conflicts = 10.

Source files
------------

// File: rtl/proc_mem_arbiter_pkg.sv
// ============================================================================
// proc_mem_arbiter_pkg: shared types for the processor memory arbiter. Rev 1.0
// ============================================================================
`default_nettype none

package proc_mem_arbiter_pkg;

    // Memory message layouts (4-byte data variants)
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam int REQ_MSG_W  = $bits(mem_req_4B_t);
    localparam int RESP_MSG_W = $bits(mem_resp_4B_t);

    typedef logic req_id_t;

    localparam req_id_t REQ_ID_IMEM = 1'b0;
    localparam req_id_t REQ_ID_DMEM = 1'b1;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/proc_mem_arb_owner_fifo.sv
// ============================================================================
// proc_mem_arb_owner_fifo: in-order FIFO of requester ids for in-flight
// memory requests, with simultaneous push/pop. Rev 1.0
// ============================================================================
`default_nettype none

module proc_mem_arb_owner_fifo
    import proc_mem_arbiter_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t head_id,
    output logic    full,
    output logic    empty
);

    localparam int              c_AW       = $clog2(p_depth);
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(p_depth);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    req_id_t         r_mem [p_depth];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full    = (r_count == c_CNT_FULL);
    assign empty   = (r_count == '0);
    assign head_id = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_mem_arbiter.sv
// ============================================================================
// proc_mem_arbiter: round-robin sharing of one memory port between imem
// (port 0) and dmem (port 1). Optional stats: PROC_MEM_ARB_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [REQ_MSG_W-1:0]  req0_msg,
    input  logic                  req0_val,
    output logic                  req0_rdy,
    input  logic [REQ_MSG_W-1:0]  req1_msg,
    input  logic                  req1_val,
    output logic                  req1_rdy,

    output logic [RESP_MSG_W-1:0] resp0_msg,
    output logic                  resp0_val,
    input  logic                  resp0_rdy,
    output logic [RESP_MSG_W-1:0] resp1_msg,
    output logic                  resp1_val,
    input  logic                  resp1_rdy,

    output logic [REQ_MSG_W-1:0]  memreq_msg,
    output logic                  memreq_val,
    input  logic                  memreq_rdy,
    input  logic [RESP_MSG_W-1:0] memresp_msg,
    input  logic                  memresp_val,
    output logic                  memresp_rdy
`ifdef PROC_MEM_ARB_STATS_EN
    ,
    output logic [31:0]           num_grants0,
    output logic [31:0]           num_grants1,
    output logic [31:0]           num_conflicts
`endif
);

    arb_state_t r_state;
    req_id_t    r_ptr;
    req_id_t    r_lock_id;

    logic       w_full;
    logic       w_empty;
    req_id_t    w_head;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_present;
    req_id_t    w_winner;
    logic       w_fire;
    logic       w_pop;

    // A held request is presented regardless of FIFO level: it cannot fill while holding.
    always_comb begin
        w_elig0   = 1'b0;
        w_elig1   = 1'b0;
        w_winner  = r_ptr;
        w_present = 1'b0;
        if (r_state == HOLD) begin
            w_winner  = r_lock_id;
            w_present = (r_lock_id == REQ_ID_DMEM) ? req1_val : req0_val;
        end else begin
            w_elig0 = req0_val && !w_full;
            w_elig1 = req1_val && !w_full;
            if (w_elig0 && w_elig1) begin
                w_winner = r_ptr;
            end else if (w_elig1) begin
                w_winner = REQ_ID_DMEM;
            end else begin
                w_winner = REQ_ID_IMEM;
            end
            w_present = w_elig0 || w_elig1;
        end
    end

    assign memreq_val = !reset && w_present;
    assign memreq_msg = (w_winner == REQ_ID_DMEM) ? req1_msg : req0_msg;
    assign w_fire     = memreq_val && memreq_rdy;
    assign req0_rdy   = w_fire && (w_winner == REQ_ID_IMEM);
    assign req1_rdy   = w_fire && (w_winner == REQ_ID_DMEM);

    // Responses are broadcast; only the FIFO head owner sees a valid.
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign resp0_val   = !reset && memresp_val && !w_empty && (w_head == REQ_ID_IMEM);
    assign resp1_val   = !reset && memresp_val && !w_empty && (w_head == REQ_ID_DMEM);
    assign memresp_rdy = !reset && !w_empty &&
                         ((w_head == REQ_ID_DMEM) ? resp1_rdy : resp0_rdy);
    assign w_pop       = memresp_val && memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB;
            r_ptr     <= REQ_ID_IMEM;
            r_lock_id <= REQ_ID_IMEM;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_present) begin
                        if (memreq_rdy) begin
                            r_ptr <= ~w_winner;
                        end else begin
                            r_lock_id <= w_winner;
                            r_state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_fire) begin
                        r_ptr   <= ~r_lock_id;
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    proc_mem_arb_owner_fifo #(
        .p_depth (p_max_outstanding)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_fire),
        .push_id (w_winner),
        .pop     (w_pop),
        .head_id (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

`ifdef PROC_MEM_ARB_STATS_EN
    logic [31:0] r_grants0;
    logic [31:0] r_grants1;
    logic [31:0] r_conflicts;

    assign num_grants0   = r_grants0;
    assign num_grants1   = r_grants1;
    assign num_conflicts = r_conflicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grants0   <= '0;
            r_grants1   <= '0;
            r_conflicts <= '0;
        end else begin
            if (req0_rdy && (r_grants0 != '1)) begin
                r_grants0 <= r_grants0 + 32'd1;
            end
            if (req1_rdy && (r_grants1 != '1)) begin
                r_grants1 <= r_grants1 + 32'd1;
            end
            if ((r_state == ARB) && req0_val && req1_val && !w_full &&
                (r_conflicts != '1)) begin
                r_conflicts <= r_conflicts + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding has no owner to steer to.
    a_no_resp_when_empty: assert property (
        @(posedge clk) disable iff (reset) !(memresp_val && w_empty)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_mem_arbiter.sv
// ============================================================================
// tb_proc_mem_arbiter: randomized and directed bench for proc_mem_arbiter;
// stats checks enabled with PROC_MEM_ARB_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_proc_mem_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] req0_msg, req1_msg, memreq_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [46:0] resp0_msg, resp1_msg, memresp_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
`ifdef PROC_MEM_ARB_STATS_EN
    logic [31:0] num_grants0, num_grants1, num_conflicts;
`endif

    always #5 clk = ~clk;

    proc_mem_arbiter #(.p_max_outstanding(MAXO)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
`ifdef PROC_MEM_ARB_STATS_EN
        , .num_grants0(num_grants0), .num_grants1(num_grants1), .num_conflicts(num_conflicts)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: owners of outstanding requests, rotating priority, held grant (-1 = none)
    int m_ptr;
    int m_lock;
    int m_own[$];
    bit last_acc0, last_acc1;

    // In-order memory with fixed latency
    logic [76:0] mem_q[$];
    int          mem_t[$];
    int          mem_lat = 1;
    bit          mem_en  = 1'b1;

    // What the DUT actually granted / returned
    int          g_obs[$];
    logic [31:0] r0_data[$];
    logic [31:0] r1_data[$];

    function automatic logic [76:0] mk_req(input logic [31:0] addr);
        return {3'd0, 8'($urandom), addr, 2'd0, 32'($urandom)};
    endfunction

    // Response carries the request address as its data word
    function automatic logic [46:0] mem_resp(input logic [76:0] r);
        return {r[76:74], r[73:66], 2'b00, r[33:32], r[65:34]};
    endfunction

    task automatic model_clear();
        m_ptr = 0;
        m_lock = -1;
        m_own.delete();
        mem_q.delete();
        mem_t.delete();
        g_obs.delete();
        r0_data.delete();
        r1_data.delete();
        last_acc0 = 1'b0;
        last_acc1 = 1'b0;
    endtask

    task automatic drive_mem();
        memresp_val = 1'b0;
        memresp_msg = '0;
        if (mem_q.size() > 0) begin
            memresp_msg = mem_resp(mem_q[0]);
            memresp_val = mem_en && ((cyc - mem_t[0]) >= mem_lat);
        end
    endtask

    // One clock: called in the low phase with inputs set; returns at the next negedge.
    task automatic cycle(input string tag);
        bit full, empty, e0, e1, ev, fire, pop;
        int ew, head;
        logic [5:0] exp_c, got_c;
        drive_mem();
        #1;
        full  = (m_own.size() == MAXO);
        empty = (m_own.size() == 0);
        if (m_lock >= 0) begin
            ew = m_lock;
            ev = (ew == 1) ? req1_val : req0_val;
        end else begin
            e0 = req0_val && !full;
            e1 = req1_val && !full;
            ev = e0 || e1;
            ew = (e0 && e1) ? m_ptr : (e1 ? 1 : 0);
        end
        head = empty ? 0 : m_own[0];
        fire = ev && memreq_rdy;
        pop  = memresp_val && !empty && ((head == 1) ? resp1_rdy : resp0_rdy);
        exp_c = {ev, fire && (ew == 0), fire && (ew == 1),
                 memresp_val && !empty && (head == 0),
                 memresp_val && !empty && (head == 1),
                 !empty && ((head == 1) ? resp1_rdy : resp0_rdy)};
        got_c = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
        total++;
        if (got_c !== exp_c) begin
            bad++;
            $display("FAIL %s ctl cyc=%0d got=%b exp=%b (mv,r0,r1,rv0,rv1,mr)", tag, cyc, got_c, exp_c);
        end
        if (ev) begin
            total++;
            if (memreq_msg !== ((ew == 1) ? req1_msg : req0_msg)) begin
                bad++;
                $display("FAIL %s memreq_msg cyc=%0d got=%h exp=%h", tag, cyc, memreq_msg,
                         (ew == 1) ? req1_msg : req0_msg);
            end
        end
        if (memresp_val && !empty) begin
            total++;
            if ({resp0_msg, resp1_msg} !== {memresp_msg, memresp_msg}) begin
                bad++;
                $display("FAIL %s resp_msg cyc=%0d got=%h/%h exp=%h", tag, cyc, resp0_msg, resp1_msg, memresp_msg);
            end
        end
        if (req0_val && req0_rdy) g_obs.push_back(0);
        if (req1_val && req1_rdy) g_obs.push_back(1);
        if (resp0_val && resp0_rdy) r0_data.push_back(resp0_msg[31:0]);
        if (resp1_val && resp1_rdy) r1_data.push_back(resp1_msg[31:0]);
        if (pop) begin
            m_own.delete(0);
            mem_q.delete(0);
            mem_t.delete(0);
        end
        if (fire) begin
            m_own.push_back(ew);
            mem_q.push_back((ew == 1) ? req1_msg : req0_msg);
            mem_t.push_back(cyc);
            m_ptr  = 1 - ew;
            m_lock = -1;
        end else if (ev) begin
            m_lock = ew;
        end
        last_acc0 = fire && (ew == 0);
        last_acc1 = fire && (ew == 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        req0_val = 1'b1; req1_val = 1'b1;
        req0_msg = mk_req(32'h100); req1_msg = mk_req(32'h2000);
        memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        memresp_val = 1'b1; memresp_msg = 47'($urandom);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
                bad++;
                $display("FAIL %s in_reset got=%b exp=000000", tag,
                         {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy});
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        reset = 1'b0;
        req0_val = 1'b0; req1_val = 1'b0;
        memresp_val = 1'b0;
        model_clear();
        #1;
        total++;
        if ({memreq_val, memresp_rdy} !== 2'b00) begin
            bad++;
            $display("FAIL %s after_reset got=%b exp=00 (empty fifo)", tag, {memreq_val, memresp_rdy});
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_alternate();
        apply_reset("alt_rst");
        req0_val = 1'b1; req1_val = 1'b1;
        req0_msg = mk_req(32'h100); req1_msg = mk_req(32'h2000);
        memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mem_en = 1'b1; mem_lat = 1;
        for (int i = 0; i < 8; i++) cycle("alt");
        for (int i = 0; i < 8; i++) begin
            total++;
            if (g_obs.size() <= i || g_obs[i] != (i % 2)) begin
                bad++;
                $display("FAIL alt_grant idx=%0d got=%0d exp=%0d", i,
                         (g_obs.size() > i) ? g_obs[i] : -1, i % 2);
            end
        end
        total++;
        if (r0_data.size() == 0 || r0_data[0] !== 32'h100) begin
            bad++;
            $display("FAIL alt_resp0 got_n=%0d exp first addr=00000100", r0_data.size());
        end
        total++;
        if (r1_data.size() == 0 || r1_data[0] !== 32'h2000) begin
            bad++;
            $display("FAIL alt_resp1 got_n=%0d exp first addr=00002000", r1_data.size());
        end
    endtask

    task automatic test_hold();
        apply_reset("hold_rst");
        mem_en = 1'b0;
        req1_val = 1'b1; req1_msg = mk_req(32'h2004);
        memreq_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                req0_val = 1'b1;
                req0_msg = mk_req(32'h100);
            end
            #1;
            total++;
            if (memreq_msg[65:34] !== 32'h2004 || memreq_val !== 1'b1) begin
                bad++;
                $display("FAIL hold_msg c=%0d got addr=%h val=%b exp addr=00002004 val=1", c, memreq_msg[65:34], memreq_val);
            end
            cycle("hold");
        end
        memreq_rdy = 1'b1;
        #1;
        total++;
        if ({req0_rdy, req1_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL hold_fire got r0,r1=%b exp=01", {req0_rdy, req1_rdy});
        end
        cycle("hold");
        req1_val = 1'b0;
        #1;
        total++;
        if (req0_rdy !== 1'b1 || memreq_msg[65:34] !== 32'h100) begin
            bad++;
            $display("FAIL hold_next got r0=%b addr=%h exp r0=1 addr=00000100", req0_rdy, memreq_msg[65:34]);
        end
        cycle("hold");
    endtask

    task automatic test_full();
        int n;
        apply_reset("full_rst");
        req0_val = 1'b1; req1_val = 1'b1;
        memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mem_en = 1'b0; mem_lat = 1;
        for (int i = 0; i < 7; i++) cycle("full");
        #1;
        total++;
        if (g_obs.size() != MAXO || memreq_val !== 1'b0) begin
            bad++;
            $display("FAIL full_cap got fires=%0d val=%b exp fires=%0d val=0", g_obs.size(), memreq_val, MAXO);
        end
        mem_en = 1'b1;
        cycle("full_pop");
        mem_en = 1'b0;
        n = g_obs.size();
        cycle("full_refill");
        total++;
        if (g_obs.size() != n + 1) begin
            bad++;
            $display("FAIL full_refill got fires=%0d exp=%0d", g_obs.size(), n + 1);
        end
        cycle("full_again");
        total++;
        if (g_obs.size() != n + 1) begin
            bad++;
            $display("FAIL full_again got fires=%0d exp=%0d", g_obs.size(), n + 1);
        end
    endtask

    task automatic test_resp_stall();
        apply_reset("stall_rst");
        mem_en = 1'b0; memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        req1_val = 1'b1; req1_msg = mk_req(32'h3000);
        cycle("stall_iss");
        req1_val = 1'b0; req0_val = 1'b1; req0_msg = mk_req(32'h400);
        cycle("stall_iss");
        req0_val = 1'b0;
        mem_en = 1'b1; mem_lat = 1; resp1_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_mem();
            #1;
            total++;
            if ({memresp_rdy, resp0_val, resp1_val} !== 3'b001) begin
                bad++;
                $display("FAIL stall i=%0d got mr,rv0,rv1=%b exp=001", i, {memresp_rdy, resp0_val, resp1_val});
            end
            cycle("stall");
        end
        resp1_rdy = 1'b1;
        cycle("stall_drain");
        cycle("stall_drain");
        total++;
        if (r1_data.size() != 1 || r0_data.size() != 1 || r1_data[0] !== 32'h3000 || r0_data[0] !== 32'h400) begin
            bad++;
            $display("FAIL stall_order got n1=%0d n0=%0d exp one each (3000,400)", r1_data.size(), r0_data.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset("mid_rst0");
        mem_en = 1'b0; memreq_rdy = 1'b1;
        req0_val = 1'b1; req1_val = 1'b1;
        for (int i = 0; i < 3; i++) cycle("mid_iss");
        total++;
        if (g_obs.size() != 3) begin
            bad++;
            $display("FAIL mid_outstanding got=%0d exp=3", g_obs.size());
        end
        apply_reset("mid_rst");
        mem_en = 1'b1;
        req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
        cycle("mid_fresh");
        total++;
        if (g_obs.size() == 0 || g_obs[0] != 0) begin
            bad++;
            $display("FAIL mid_first_grant got=%0d exp=0", (g_obs.size() > 0) ? g_obs[0] : -1);
        end
    endtask

    task automatic test_random(input int n);
        apply_reset("rnd_rst");
        mem_lat = 2;
        for (int i = 0; i < n; i++) begin
            if (!(req0_val && !last_acc0)) begin
                req0_val = ($urandom % 3) != 0;
                req0_msg = mk_req($urandom);
            end
            if (!(req1_val && !last_acc1)) begin
                req1_val = ($urandom % 3) != 0;
                req1_msg = mk_req($urandom);
            end
            memreq_rdy = ($urandom % 4) != 0;
            resp0_rdy  = ($urandom % 4) != 0;
            resp1_rdy  = ($urandom % 4) != 0;
            mem_en     = ($urandom % 3) != 0;
            cycle("rnd");
        end
    endtask

`ifdef PROC_MEM_ARB_STATS_EN
    task automatic test_stats();
        apply_reset("stats_rst");
        req0_val = 1'b1; req1_val = 1'b1;
        memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mem_en = 1'b1; mem_lat = 1;
        for (int i = 0; i < 10; i++) cycle("stats");
        #1;
        total++;
        if (num_grants0 !== 32'd5 || num_grants1 !== 32'd5 || num_conflicts !== 32'd10) begin
            bad++;
            $display("FAIL stats got g0=%0d g1=%0d cf=%0d exp 5 5 10", num_grants0, num_grants1, num_conflicts);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0; req1_msg = '0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
        model_clear();
        test_reset();
        test_alternate();
        test_hold();
        test_full();
        test_resp_stall();
        test_reset_mid();
        test_random(400);
`ifdef PROC_MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
